// File: rtl/gpu_rf_pkg.sv
// Shared widths, FSM encodings and writeback payload for the per-thread
// register-file access controller.
package gpu_rf_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned ADDR_W        = 4;
    localparam int unsigned NUM_REGS      = 16;
    localparam int unsigned FIRST_SPECIAL = 13;
    localparam int unsigned STATE_W       = 2;

    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] CHECK = 2'd1;
    localparam logic [STATE_W-1:0] HOLD  = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Registers 13..15 hold block_idx/block_dim/thread_idx and are read-only.
    function automatic logic is_special(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_W'(FIRST_SPECIAL);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set wins over clear,
// read-only special registers never become pending.
module rf_scoreboard
    import gpu_rf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en_i,
    input  logic [ADDR_W-1:0]   set_idx_i,
    input  logic                clr_en_i,
    input  logic [ADDR_W-1:0]   clr_idx_i,
    output logic [NUM_REGS-1:0] sb_o
);

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic [NUM_REGS-1:0] special_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        special_mask = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            special_mask[i] = (i >= int'(FIRST_SPECIAL));
        end
    end

    always_comb begin
        set_mask = set_en_i ? (NUM_REGS'(1) << set_idx_i) : '0;
        clr_mask = clr_en_i ? (NUM_REGS'(1) << clr_idx_i) : '0;
        sb_d     = ((sb_q & ~clr_mask) | set_mask) & ~special_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign sb_o = sb_q;

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file initiator: hazard-checked operand read and LSU>ALU writeback
// arbitration. Define WB_BYPASS_EN to forward same-cycle writebacks into CHECK.
module reg_access_ctrl
    import gpu_rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_wr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_rs1_data,
    output logic [DATA_W-1:0] op_rs2_data,
    output logic [ADDR_W-1:0] op_rd,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [ADDR_W-1:0] alu_wb_rd,
    input  logic [DATA_W-1:0] alu_wb_data,
    input  logic              lsu_wb_valid,
    output logic              lsu_wb_ready,
    input  logic [ADDR_W-1:0] lsu_wb_rd,
    input  logic [DATA_W-1:0] lsu_wb_data,
    output logic [ADDR_W-1:0] rf_A1,
    output logic [ADDR_W-1:0] rf_A2,
    output logic [ADDR_W-1:0] rf_A3,
    output logic [DATA_W-1:0] rf_WD,
    output logic              rf_we,
    output logic              rf_reg_en,
    input  logic [DATA_W-1:0] rf_RS1,
    input  logic [DATA_W-1:0] rf_RS2,
    output logic              wb_drop
);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                op_valid_q, op_valid_d;
    logic [DATA_W-1:0]   op_rs1_q, op_rs1_d, op_rs2_q, op_rs2_d;
    logic [ADDR_W-1:0]   op_rd_q, op_rd_d;
    logic                wb_drop_q, wb_drop_d;
    logic                sb_set_en;
    logic [NUM_REGS-1:0] sb;

    wb_req_t alu_req, lsu_req, win_req;
    logic    fwd1, fwd2, haz1, haz2, hazd, hazard;

    assign alu_req = {alu_wb_valid, alu_wb_rd, alu_wb_data};
    assign lsu_req = {lsu_wb_valid, lsu_wb_rd, lsu_wb_data};

    // Fixed-priority writeback arbitration; special targets are acked but not written.
    always_comb begin
        win_req      = lsu_req.valid ? lsu_req : alu_req;
        lsu_wb_ready = lsu_req.valid;
        alu_wb_ready = alu_req.valid & ~lsu_req.valid;
        rf_A3        = win_req.valid ? win_req.rd   : '0;
        rf_WD        = win_req.valid ? win_req.data : '0;
        rf_we        = win_req.valid & ~is_special(win_req.rd);
        wb_drop_d    = win_req.valid &  is_special(win_req.rd);
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        fwd1 = rf_we && (win_req.rd == rs1_q);
        fwd2 = rf_we && (win_req.rd == rs2_q);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        haz1   = sb[rs1_q] & ~fwd1;
        haz2   = sb[rs2_q] & ~fwd2;
        hazd   = wr_q & sb[rd_q];
        hazard = haz1 | haz2 | hazd;
    end

    rf_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (sb_set_en),
        .set_idx_i (rd_q),
        .clr_en_i  (rf_we),
        .clr_idx_i (win_req.rd),
        .sb_o      (sb)
    );

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        op_valid_d = op_valid_q;
        op_rs1_d   = op_rs1_q;
        op_rs2_d   = op_rs2_q;
        op_rd_d    = op_rd_q;
        sb_set_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    rs1_d   = issue_rs1;
                    rs2_d   = issue_rs2;
                    rd_d    = issue_rd;
                    wr_d    = issue_wr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!hazard) begin
                    op_valid_d = 1'b1;
                    op_rs1_d   = fwd1 ? win_req.data : rf_RS1;
                    op_rs2_d   = fwd2 ? win_req.data : rf_RS2;
                    op_rd_d    = rd_q;
                    sb_set_en  = wr_q & ~is_special(rd_q);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            op_valid_q <= 1'b0;
            op_rs1_q   <= '0;
            op_rs2_q   <= '0;
            op_rd_q    <= '0;
            wb_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            op_valid_q <= op_valid_d;
            op_rs1_q   <= op_rs1_d;
            op_rs2_q   <= op_rs2_d;
            op_rd_q    <= op_rd_d;
            wb_drop_q  <= wb_drop_d;
        end
    end

    // Reset must drop issue_ready immediately, even though state already reads IDLE.
    assign issue_ready = (state_q == IDLE) & ~reset;
    assign op_valid    = op_valid_q;
    assign op_rs1_data = op_rs1_q;
    assign op_rs2_data = op_rs2_q;
    assign op_rd       = op_rd_q;
    assign rf_A1       = rs1_q;
    assign rf_A2       = rs2_q;
    assign rf_reg_en   = (state_q == CHECK) | rf_we;
    assign wb_drop     = wb_drop_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file.
module tb_reg_access_ctrl;

    logic        clk, reset;
    logic        issue_valid, issue_ready, issue_wr;
    logic [3:0]  issue_rs1, issue_rs2, issue_rd;
    logic        op_valid, op_ready;
    logic [15:0] op_rs1_data, op_rs2_data;
    logic [3:0]  op_rd;
    logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
    logic [3:0]  alu_wb_rd, lsu_wb_rd;
    logic [15:0] alu_wb_data, lsu_wb_data;
    logic [3:0]  rf_A1, rf_A2, rf_A3;
    logic [15:0] rf_WD, rf_RS1, rf_RS2;
    logic        rf_we, rf_reg_en, wb_drop;

    logic [15:0] rf_m [16];
    int n_cmp = 0;
    int n_bad = 0;

    reg_access_ctrl dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data), .op_rd(op_rd),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .rf_A1(rf_A1), .rf_A2(rf_A2), .rf_A3(rf_A3), .rf_WD(rf_WD),
        .rf_we(rf_we), .rf_reg_en(rf_reg_en),
        .rf_RS1(rf_RS1), .rf_RS2(rf_RS2),
        .wb_drop(wb_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: r1=5, r2=7, specials 13..15, others i*0x0101.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf_m[i] <= 16'(i) * 16'h0101;
            rf_m[1]  <= 16'h0005;
            rf_m[2]  <= 16'h0007;
            rf_m[13] <= 16'h0003;
            rf_m[14] <= 16'h0040;
            rf_m[15] <= 16'h0007;
        end else if (rf_we) begin
            rf_m[rf_A3] <= rf_WD;
        end
    end
    assign rf_RS1 = rf_m[rf_A1];
    assign rf_RS2 = rf_m[rf_A2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic wr);
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_wr    = wr;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_wr = 0;
        op_ready = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
        #3;
        chk("rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_op_valid",    32'(op_valid),    32'd0);
        chk("rst_op_rd",       32'(op_rd),       32'd0);
        chk("rst_rf_we",       32'(rf_we),       32'd0);
        chk("rst_wb_drop",     32'(wb_drop),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_issue_ready", 32'(issue_ready), 32'd1);
        tick();

        // Basic issue, 2-cycle latency, then 4-cycle backpressure
        issue(4'd1, 4'd2, 4'd3, 1'b1);
        chk("t1_check_issue_ready", 32'(issue_ready), 32'd0);
        chk("t1_check_op_valid",    32'(op_valid),    32'd0);
        chk("t1_rf_A1",             32'(rf_A1),       32'd1);
        chk("t1_rf_A2",             32'(rf_A2),       32'd2);
        chk("t1_reg_en",            32'(rf_reg_en),   32'd1);
        tick();
        chk("t1_op_valid", 32'(op_valid),    32'd1);
        chk("t1_rs1_data", 32'(op_rs1_data), 32'h5);
        chk("t1_rs2_data", 32'(op_rs2_data), 32'h7);
        chk("t1_op_rd",    32'(op_rd),       32'd3);
        chk("t1_sb3",      32'(dut.u_sb.sb_o[3]), 32'd1);
        chk("t1_hold_reg_en", 32'(rf_reg_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_op_valid",    32'(op_valid),    32'd1);
            chk("hold_rs1_data",    32'(op_rs1_data), 32'h5);
            chk("hold_op_rd",       32'(op_rd),       32'd3);
            chk("hold_issue_ready", 32'(issue_ready), 32'd0);
        end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("release_op_valid",    32'(op_valid),    32'd0);
        chk("release_issue_ready", 32'(issue_ready), 32'd1);

        // RAW stall on r3 until the ALU writeback lands
        issue(4'd3, 4'd0, 4'd4, 1'b1);
        tick();
        chk("raw_stall0", 32'(op_valid), 32'd0);
        tick();
        chk("raw_stall1", 32'(op_valid), 32'd0);
        alu_wb_valid = 1'b1; alu_wb_rd = 4'd3; alu_wb_data = 16'h00AA;
        #1;
        chk("raw_alu_ready", 32'(alu_wb_ready), 32'd1);
        chk("raw_rf_we",     32'(rf_we),        32'd1);
        chk("raw_rf_A3",     32'(rf_A3),        32'd3);
        chk("raw_rf_WD",     32'(rf_WD),        32'h00AA);
        tick();
        alu_wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("raw_byp_op_valid", 32'(op_valid), 32'd1);
`else
        chk("raw_nobyp_stall", 32'(op_valid), 32'd0);
        tick();
        chk("raw_op_valid", 32'(op_valid), 32'd1);
`endif
        chk("raw_rs1_data", 32'(op_rs1_data), 32'h00AA);
        chk("raw_rs2_data", 32'(op_rs2_data), 32'h0000);
        chk("raw_op_rd",    32'(op_rd),       32'd4);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("raw_back_idle", 32'(issue_ready), 32'd1);

        // Simultaneous LSU and ALU writebacks: LSU first
        alu_wb_valid = 1'b1; alu_wb_rd = 4'd4; alu_wb_data = 16'h1111;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 4'd5; lsu_wb_data = 16'h2222;
        #1;
        chk("arb_rf_A3_lsu",  32'(rf_A3),        32'd5);
        chk("arb_rf_WD_lsu",  32'(rf_WD),        32'h2222);
        chk("arb_lsu_ready",  32'(lsu_wb_ready), 32'd1);
        chk("arb_alu_ready0", 32'(alu_wb_ready), 32'd0);
        tick();
        lsu_wb_valid = 1'b0;
        #1;
        chk("arb_rf_A3_alu",  32'(rf_A3),        32'd4);
        chk("arb_rf_WD_alu",  32'(rf_WD),        32'h1111);
        chk("arb_alu_ready1", 32'(alu_wb_ready), 32'd1);
        tick();
        alu_wb_valid = 1'b0;
        #1;
        chk("arb_idle_rf_we", 32'(rf_we),   32'd0);
        chk("arb_idle_rf_A3", 32'(rf_A3),   32'd0);
        chk("arb_r5",         32'(rf_m[5]), 32'h2222);
        chk("arb_r4",         32'(rf_m[4]), 32'h1111);
        chk("arb_sb4_clear",  32'(dut.u_sb.sb_o[4]), 32'd0);

        // Writeback to special register is dropped
        lsu_wb_valid = 1'b1; lsu_wb_rd = 4'd14; lsu_wb_data = 16'hFFFF;
        #1;
        chk("spec_rf_we",     32'(rf_we),        32'd0);
        chk("spec_lsu_ready", 32'(lsu_wb_ready), 32'd1);
        chk("spec_drop_pre",  32'(wb_drop),      32'd0);
        tick();
        lsu_wb_valid = 1'b0;
        chk("spec_drop_pulse", 32'(wb_drop), 32'd1);
        tick();
        chk("spec_drop_end", 32'(wb_drop),  32'd0);
        chk("spec_r14_kept", 32'(rf_m[14]), 32'h0040);

        // Reset while CHECK is stalled on pending r6
        issue(4'd0, 4'd0, 4'd6, 1'b1);
        tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        issue(4'd6, 4'd0, 4'd0, 1'b0);
        tick();
        chk("rst_mid_stall", 32'(op_valid), 32'd0);
        chk("rst_mid_sb6",   32'(dut.u_sb.sb_o[6]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_op_valid",    32'(op_valid),    32'd0);
        chk("rst_mid_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_mid_sb",          32'(dut.u_sb.sb_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rel_issue_ready", 32'(issue_ready), 32'd1);
        issue_rs1 = 4'd6; issue_rs2 = 4'd0; issue_rd = 4'd0; issue_wr = 1'b0;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();
        chk("rst_rel_op_valid", 32'(op_valid),    32'd1);
        chk("rst_rel_rs1_data", 32'(op_rs1_data), 32'h0606);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
